// File: rtl/scan_scheduler.sv
// Seven-segment scan scheduler: walks the enabled digits one slot at a time,
// blanks the anodes at the start of each slot, and applies 16-level PWM
// during the on phase. All outputs decode from registered state only.
module scan_scheduler #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] en_mask,
  input  logic [3:0] duty,
  output logic [7:0] a,
  output logic [2:0] sel,
  output logic       frame_start
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  typedef enum logic {StOff, StScan} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [7:0]      mask_q, mask_d;
  logic [3:0]      duty_q, duty_d;

  logic            blank;
  logic [3:0]      phase;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) res = 3'(i);
    end
    return res;
  endfunction

  // Next set bit searching upward from cur+1 with wrap; returns cur if it is
  // the only set bit (the k=8 step lands back on cur).
  function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && m[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // State and slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StOff;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      mask_q  <= 8'd0;
      duty_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      duty_q  <= duty_d;
    end
  end

  // Next-state: start scanning on a nonzero mask, advance digits at slot ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    duty_d  = duty_q;
    unique case (state_q)
      StOff: begin
        if (|en_mask) begin
          state_d = StScan;
          mask_d  = en_mask;
          duty_d  = duty;
          sel_d   = lowest_bit(en_mask);
          cnt_d   = '0;
        end
      end
      StScan: begin
        if (cnt_q == CntMax) begin
          cnt_d  = '0;
          mask_d = en_mask;
          duty_d = duty;
          if (en_mask == 8'd0) begin
            state_d = StOff;
          end else begin
            sel_d = next_bit(en_mask, sel_q);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Output decode: blank phase, then PWM on phase keyed to cnt offset mod 16.
  always_comb begin
    a           = 8'hFF;
    frame_start = 1'b0;
    sel         = sel_q;
    blank       = 32'(cnt_q) < BLANK_CYCLES;
    phase       = 4'(32'(cnt_q) - BLANK_CYCLES);
    if (state_q == StScan) begin
      if (!blank && (phase <= duty_q)) a[sel_q] = 1'b0;
      frame_start = (cnt_q == '0) && (sel_q == lowest_bit(mask_q));
    end
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: directed scenarios plus random masks/duty, all
// checked cycle by cycle against a slot-level reference model.
module tb_scan_scheduler;

  localparam int Div   = 8;
  localparam int Blank = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] en_mask;
  logic [3:0] duty;
  logic [7:0] a;
  logic [2:0] sel;
  logic       frame_start;

  int vectors = 0;
  int errors  = 0;

  // Reference model: "on" flag, position within slot, owning digit, and the
  // mask/duty captured for the current slot.
  bit   m_on;
  int   m_pos;
  int   m_digit;
  bit [7:0] m_mask;
  int   m_duty;

  scan_scheduler #(.CLK_DIV(Div), .BLANK_CYCLES(Blank)) dut (
    .clk(clk), .reset(reset), .en_mask(en_mask), .duty(duty),
    .a(a), .sel(sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic int first_digit(input bit [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int following_digit(input bit [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  function automatic logic [7:0] model_a();
    int p;
    if (!m_on || m_pos < Blank) return 8'hFF;
    p = (m_pos - Blank) % 16;
    if (p <= m_duty) return ~(8'h01 << m_digit);
    return 8'hFF;
  endfunction

  function automatic logic model_fs();
    return m_on && m_pos == 0 && m_digit == first_digit(m_mask);
  endfunction

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_digit = 0; m_mask = 0; m_duty = 0;
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (a === model_a()) else begin
      errors++;
      $error("FAIL %s a: got %h expected %h", tag, a, model_a());
    end
    vectors++;
    assert (sel === 3'(m_digit)) else begin
      errors++;
      $error("FAIL %s sel: got %0d expected %0d", tag, sel, m_digit);
    end
    vectors++;
    assert (frame_start === model_fs()) else begin
      errors++;
      $error("FAIL %s frame_start: got %b expected %b", tag, frame_start, model_fs());
    end
  endtask

  // One clock: work out the model's next slot state from the inputs seen at
  // this edge, then compare the DUT 1 time unit after the edge.
  task automatic step(input string tag);
    bit   n_on;
    int   n_pos, n_digit, n_duty;
    bit [7:0] n_mask;
    n_on = m_on; n_pos = m_pos; n_digit = m_digit; n_mask = m_mask; n_duty = m_duty;
    if (!m_on) begin
      if (en_mask != 0) begin
        n_on = 1; n_pos = 0; n_mask = en_mask; n_duty = duty;
        n_digit = first_digit(en_mask);
      end
    end else if (m_pos == Div - 1) begin
      n_pos = 0; n_mask = en_mask; n_duty = duty;
      if (en_mask == 0) n_on = 0;
      else n_digit = following_digit(en_mask, m_digit);
    end else begin
      n_pos = m_pos + 1;
    end
    @(posedge clk);
    #1;
    m_on = n_on; m_pos = n_pos; m_digit = n_digit; m_mask = n_mask; m_duty = n_duty;
    check(tag);
  endtask

  // Advance until the model sits on the last cycle of a slot.
  task automatic align_to_slot_end();
    for (int i = 0; i < 2 * Div && !(m_on && m_pos == Div - 1); i++) step("align");
  endtask

  task automatic count_lit(input int d, input string tag);
    int lit;
    int want;
    duty = 4'(d);
    align_to_slot_end();
    lit = 0;
    for (int i = 0; i < Div; i++) begin
      step(tag);
      if (a !== 8'hFF) lit++;
    end
    want = (d + 1 < Div - Blank) ? d + 1 : Div - Blank;
    vectors++;
    assert (lit === want) else begin
      errors++;
      $error("FAIL %s lit cycles: got %0d expected %0d", tag, lit, want);
    end
  endtask

  initial begin
    reset = 1'b0; en_mask = 8'h00; duty = 4'd0;
    model_reset();
    #2;
    check("reset");

    // Full mask, full brightness.
    en_mask = 8'hFF; duty = 4'd15; reset = 1'b1;
    for (int i = 0; i < 72; i++) step("all_digits");

    // Sparse mask: digits 2 and 7 alternate.
    en_mask = 8'b1000_0100;
    for (int i = 0; i < 40; i++) step("sparse");

    // PWM levels and mid-slot duty change.
    en_mask = 8'h01;
    count_lit(0, "duty0");
    count_lit(2, "duty2");
    for (int i = 0; i < 3; i++) step("mid_duty_pre");
    duty = 4'd15;
    for (int i = 0; i < 12; i++) step("mid_duty");

    // Mask cleared mid-slot, then restarted on digit 4.
    en_mask = 8'h00;
    for (int i = 0; i < 14; i++) step("to_off");
    en_mask = 8'h10;
    step("restart");
    for (int i = 0; i < 10; i++) step("digit4");

    // Wrap from digit 7 to digit 0.
    en_mask = 8'b1000_0001;
    for (int i = 0; i < 34; i++) step("wrap");

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step("pre_reset");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset");
    en_mask = 8'h01;
    #1;
    reset = 1'b1;
    step("after_reset");
    for (int i = 0; i < 10; i++) step("after_reset_run");

    // Random masks and duty; empty masks fairly often to exercise OFF.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) en_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 5) == 0) duty = 4'($urandom);
      step("random");
      vectors++;
      assert ($countones(~a) <= 1) else begin
        errors++;
        $error("FAIL one_hot_low a: got %h expected at most one low bit", a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/scan_scheduler.md
Name: scan_scheduler

Overview:
Time-multiplexing scheduler for the 8-digit seven-segment display. It drives the anode vector and the digit-select bus that the digit mux and decoder consume. It sets the refresh rate from the 100 MHz board clock and inserts a blanking interval between digits to suppress ghosting. It also skips digits that are masked off and applies 16-level PWM brightness during each digit's on-time.

Parameters:
CLK_DIV, 100000, clocks per digit slot (1 kHz per digit at 100 MHz); legal range is CLK_DIV >= 2.
BLANK_CYCLES, 1000, clocks at the start of each slot with all anodes off; legal range is 0 <= BLANK_CYCLES < CLK_DIV.

Ports:
clk  input  1  board clock, 100 MHz, rising edge.
reset  input  1  asynchronous, active-low reset.
en_mask  input  8  digit enable; bit i set means digit i is scanned.
duty  input  4  brightness level, 0 (dimmest) to 15 (full).
a  output  8  anode drive, active-low; bit i low means digit i is lit.
sel  output  3  index of the digit currently owning the display.
frame_start  output  1  one-cycle pulse at the first cycle of each scan frame.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values: a=8'hFF, sel=3'd0, frame_start=0, state=OFF, slot counter cnt=0, mask_q=0, duty_q=0.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- States:
  - OFF: a=8'hFF, sel holds its value, frame_start=0. en_mask is sampled every cycle. If it is nonzero, the block latches mask_q=en_mask and duty_q=duty, sets sel to the lowest set bit of en_mask, clears cnt to 0 and enters SCAN.
  - SCAN: cnt counts 0..CLK_DIV-1 and wraps.
- Anode decode in SCAN:
  - Blank phase (cnt < BLANK_CYCLES): a=8'hFF.
  - On phase (cnt >= BLANK_CYCLES): let p = (cnt - BLANK_CYCLES) mod 16. Then a[sel]=0 if p <= duty_q, else a[sel]=1. All other bits of a are 1.
  - At most one bit of a is ever low.
- Slot boundary, i.e. the cycle with cnt == CLK_DIV-1 in SCAN:
  - en_mask and duty are sampled into mask_q and duty_q. Changes to either input at any other time have no effect until the next boundary.
  - If the sampled en_mask is 0, the next state is OFF and a=8'hFF from the next cycle.
  - Otherwise sel takes the next set bit of the new mask, searching circularly upward from sel+1 and wrapping 7 to 0. If sel's own bit is the only one set, sel is unchanged.
  - cnt returns to 0.
- frame_start is 1 exactly in the first cycle (cnt == 0) of a slot whose sel equals the lowest set bit of mask_q, including slots entered from OFF. With a single enabled digit it pulses every slot.
- sel changes only on entry to a new slot. Because every slot starts with its blank phase, sel is stable whenever an anode is low. With BLANK_CYCLES=0 there is no blanking but sel still changes only at slot entry.
- Reset asserted at any point forces the reset values immediately, regardless of clk. After reset deasserts, the first rising edge samples en_mask in OFF.
- The counter width is sized to hold CLK_DIV-1. The p computation uses only the low 4 bits of the subtraction.

Test Plan:
1. CLK_DIV=8, BLANK_CYCLES=2, en_mask=8'hFF, duty=15, release reset -> each slot shows 2 cycles of a=FF followed by 6 cycles of a=~(1<<sel); sel steps 0,1,...,7,0; frame_start pulses once every 64 cycles, when sel becomes 0.
2. Same timing, en_mask=8'b1000_0100 -> sel alternates 2,7,2; a=FB then 7F during the on phases; frame_start pulses only at entry of slots with sel=2, every 16 cycles.
3. duty=0 -> exactly 1 of the 6 on-phase cycles is lit. duty=2 -> 3 lit cycles. A duty change made mid-slot takes effect only from the next slot.
4. en_mask changed to 0 mid-slot -> the current slot completes unchanged, then a=FF with the state held in OFF. en_mask then set to 8'h10 -> next cycle is SCAN with sel=4, cnt=0, frame_start=1.
5. en_mask=8'b1000_0001 with sel=7 at a boundary -> sel wraps to 0 and frame_start=1 in that slot's first cycle.
6. reset driven low mid on-phase, between clock edges -> a=FF, sel=0, frame_start=0 immediately. After release with en_mask=8'h01 -> SCAN with sel=0 one edge later.
